// File: rtl/mult_16x16_seq_pkg.sv
// Shared ALU package: multiplier FSM encoding and iteration count.
package mult_16x16_seq_pkg;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_ITER  = 16;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mult_16x16_seq_if.sv
// Start/busy/done handshake and operand/result bus between ALU control and the multiplier.
interface mult_16x16_seq_if;
  import mult_16x16_seq_pkg::*;

  logic                   start;
  logic [MUL_WIDTH-1:0]   mcand;
  logic [MUL_WIDTH-1:0]   mplier;
  logic                   busy;
  logic                   done;
  logic [2*MUL_WIDTH-1:0] product;

  // ALU control side
  modport master (
    output start, mcand, mplier,
    input  busy, done, product
  );

  // Multiplier side
  modport slave (
    input  start, mcand, mplier,
    output busy, done, product
  );

endinterface

// File: rtl/full_adder_16bit.sv
// 16-bit ripple-carry adder used as the multiplier's iteration adder.
module full_adder_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout
);

  logic [16:0] carry;

  assign carry[0] = Cin;

  // One full-adder cell per bit, chained through carry
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_bit
      assign Sum[gi]     = A[gi] ^ B[gi] ^ carry[gi];
      assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  assign Cout = carry[16];

endmodule

// File: rtl/mult_16x16_seq.sv
// Unsigned 16x16 -> 32 shift-and-add multiplier, one partial product per clock.
module mult_16x16_seq
  import mult_16x16_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  mult_16x16_seq_if.slave   bus
);

  mul_state_t             state_reg;
  mul_state_t             state_next;
  logic [WIDTH-1:0]       a_reg;
  // Low half starts as the multiplier and is shifted out as partial products
  // retire; the high half accumulates. The carry slot of the 33-bit working
  // value is always zero after the shift, so only 32 bits are stored.
  logic [2*WIDTH-1:0]     p_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [2*WIDTH-1:0]     product_reg;

  logic                   load;
  logic                   iterate;
  logic                   last_iter;
  logic [WIDTH-1:0]       addend;
  logic [WIDTH-1:0]       sum;
  logic                   cout;
  logic [2*WIDTH-1:0]     p_shift;

  assign last_iter = (cnt_reg == CNT_W'(MUL_ITER - 1));
  assign addend    = p_reg[0] ? a_reg : '0;
  // Adder carry-out becomes the new MSB so no overflow is dropped
  assign p_shift   = {cout, sum, p_reg[WIDTH-1:1]};

  full_adder_16bit u_adder (
    .A    (p_reg[2*WIDTH-1:WIDTH]),
    .B    (addend),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= MUL_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath control; start is only honoured in IDLE or DONE
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    iterate    = 1'b0;
    case (state_reg)
      MUL_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = MUL_RUN;
        end
      end
      MUL_RUN: begin
        iterate = 1'b1;
        if (last_iter) begin
          state_next = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = MUL_RUN;
        end else begin
          state_next = MUL_IDLE;
        end
      end
      default: begin
        state_next = MUL_IDLE;
      end
    endcase
  end

  // Operand capture, shift/accumulate, iteration count and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      p_reg       <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else if (load) begin
      a_reg   <= bus.mcand;
      p_reg   <= {{WIDTH{1'b0}}, bus.mplier};
      cnt_reg <= '0;
    end else if (iterate) begin
      p_reg   <= p_shift;
      cnt_reg <= cnt_reg + CNT_W'(1);
      if (last_iter) begin
        product_reg <= p_shift;
      end
    end
  end

  assign bus.busy    = (state_reg == MUL_RUN);
  assign bus.done    = (state_reg == MUL_DONE);
  assign bus.product = product_reg;

endmodule
